// File: rtl/fifo_drain_if.sv
// Read-port and output-stream bundle for fifo_drain.
// master = the drain block; slave = the FIFO read port plus the downstream sink.
interface fifo_drain_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_ren;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;

    modport master (
        input  fifo_empty, fifo_count, fifo_rdata, m_ready,
        output fifo_ren, m_valid, m_data, m_last, busy
    );

    modport slave (
        output fifo_empty, fifo_count, fifo_rdata, m_ready,
        input  fifo_ren, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/fifo_drain.sv
// Drains a 16-entry FIFO onto a valid/ready stream through a 2-entry output buffer.
// Define FIFO_DRAIN_BURST_EN to group reads into bursts with an IDLE/WAIT/DRAIN machine.
module fifo_drain #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 5,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_drain_if.master bus
);
    localparam logic CFG_OK = (BURST_LEN >= 1) && (BURST_LEN <= 16) && (TIMEOUT >= 1);

    logic [DATA_W-1:0] r_buf_data [2];
    logic [1:0]        r_buf_last;
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_occ;
    logic              r_ren_q;
    logic              r_last_q;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_pending;
    logic              w_credit;
    logic              w_allow;
    logic              w_last_tag;
    logic              w_state_busy;
    logic              w_fifo_ren;

    assign w_pop     = (r_occ != 2'd0) && bus.m_ready;
    assign w_push    = r_ren_q;
    // Words already owned (buffered or in flight) minus the one leaving this cycle.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_ren_q} - {2'b00, w_pop};
    assign w_credit  = (w_pending < 3'd2);

    assign w_fifo_ren = rst_n && CFG_OK && w_allow && !bus.fifo_empty && w_credit;

    // In-flight read tracking: remembers last cycle's read and its last tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ren_q  <= 1'b0;
            r_last_q <= 1'b0;
        end else begin
            r_ren_q  <= w_fifo_ren;
            r_last_q <= w_fifo_ren & w_last_tag;
        end
    end

    // Output buffer: in-order 2-entry ring, filled by the in-flight read, emptied by handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_data[0] <= {DATA_W{1'b0}};
            r_buf_data[1] <= {DATA_W{1'b0}};
            r_buf_last    <= 2'b00;
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_occ         <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_tail] <= bus.fifo_rdata;
                r_buf_last[r_tail] <= r_last_q;
                r_tail             <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.fifo_ren = w_fifo_ren;
    assign bus.m_valid  = (r_occ != 2'd0);
    assign bus.m_data   = r_buf_data[r_head];
    assign bus.m_last   = r_buf_last[r_head];
    assign bus.busy     = w_state_busy || (r_occ != 2'd0) || r_ren_q;

`ifdef FIFO_DRAIN_BURST_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int               REM_W     = 5;
    localparam int               TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [REM_W-1:0] BURST_REM = REM_W'(BURST_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_SAT   = TMR_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_rem_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;

    // Reads are granted only while a burst has words left to fetch.
    assign w_allow      = (r_state == ST_DRAIN) && (r_rem != {REM_W{1'b0}});
    assign w_last_tag   = (r_rem == REM_W'(1));
    assign w_state_busy = (r_state != ST_IDLE);

    // Burst state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= {REM_W{1'b0}};
            r_tmr   <= {TMR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // Burst next-state: full bursts start at once, partial ones after the WAIT timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            ST_IDLE: begin
                if (bus.fifo_count >= BURST_CNT) begin
                    w_state_nxt = ST_DRAIN;
                    w_rem_nxt   = BURST_REM;
                end else if (bus.fifo_count != {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_WAIT;
                    w_tmr_nxt   = {TMR_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_tmr != TMR_SAT) begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end else begin
                    w_tmr_nxt = r_tmr;
                end
                if (bus.fifo_count >= BURST_CNT) begin
                    w_state_nxt = ST_DRAIN;
                    w_rem_nxt   = BURST_REM;
                end else if (r_tmr == TMR_LAST) begin
                    w_state_nxt = ST_DRAIN;
                    w_rem_nxt   = REM_W'(bus.fifo_count);
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (r_rem == {REM_W{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fifo_ren) begin
                    w_rem_nxt = r_rem - REM_W'(1);
                    if (r_rem == REM_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = {REM_W{1'b0}};
                w_tmr_nxt   = {TMR_W{1'b0}};
            end
        endcase
    end
`else
    // Streaming: read whenever credit allows; the FIFO's final word closes the group.
    assign w_allow      = 1'b1;
    assign w_last_tag   = (bus.fifo_count == CNT_W'(1));
    assign w_state_busy = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: cycle tables, reset corner cases and a randomized ordering run.
module tb_fifo_drain;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;
    localparam int DEPTH  = 16;
`ifdef FIFO_DRAIN_BURST_EN
    localparam int DRAIN_WAIT = 25;
`else
    localparam int DRAIN_WAIT = 6;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         nload;
        logic [7:0] base;
        bit         rdy;
        bit         ren;
        bit         vld;
        logic [7:0] data;
        bit         last;
        bit         busy;
        int         cnt;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_drain_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fifo_drain #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         n_viol = 0;
    logic [7:0] fq[$];
    logic [7:0] pend[$];
    beat_t      rd_log[$];
    bit         seen_last[$];
    bit         chk_last;
    logic [7:0] mdl_d;
    beat_t      mdl_b;
    beat_t      mon_b;
    vec_t       vt [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bus.fifo_count <= '0;
        bus.fifo_empty <= 1'b1;
        bus.fifo_rdata <= '0;
    end

    // FIFO model: registered read data, writes land at the edge after the request.
    always @(posedge clk) begin
        if (bus.fifo_ren === 1'b1) begin
            if (fq.size() == 0) begin
                n_viol++;
            end else begin
                mdl_d = fq.pop_front();
                mdl_b.data = mdl_d;
                mdl_b.last = (fq.size() == 0);
                rd_log.push_back(mdl_b);
                bus.fifo_rdata <= mdl_d;
            end
        end
        while (pend.size() != 0) begin
            if (fq.size() == DEPTH) void'(fq.pop_front());
            fq.push_back(pend.pop_front());
        end
        bus.fifo_count <= CNT_W'(fq.size());
        bus.fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor: every accepted beat must be the next word read from the FIFO.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            seen_last.push_back(bus.m_last);
            if (rd_log.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_extra: got %0h, expected no beat", bus.m_data);
            end else begin
                mon_b = rd_log.pop_front();
                chk("beat_data", bus.m_data, mon_b.data);
                if (chk_last) chk("beat_last", bus.m_last, mon_b.last);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        bit         ren_tr [25];
        bit         done;
`ifdef FIFO_DRAIN_BURST_EN
        chk_last = 1'b0;
`else
        chk_last = 1'b1;
`endif
        bus.m_ready = 1'b1;
        pend.push_back(8'hEE);
        repeat (3) @(posedge clk);
        #1;
        // Reset state with a non-empty FIFO.
        @(negedge clk);
        chk("rst_ren",   bus.fifo_ren, 1'b0);
        chk("rst_valid", bus.m_valid,  1'b0);
        chk("rst_data",  bus.m_data,   8'h00);
        chk("rst_last",  bus.m_last,   1'b0);
        chk("rst_busy",  bus.busy,     1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (DRAIN_WAIT) @(posedge clk);
        #1;
        chk("post_rst_idle_busy",  bus.busy,       1'b0);
        chk("post_rst_idle_count", bus.fifo_count, 5'd0);

`ifndef FIFO_DRAIN_BURST_EN
        // nload words are written at the end of the row's cycle.
        vt[0]  = '{3, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1};
        vt[1]  = '{0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3};
        vt[2]  = '{0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2};
        vt[3]  = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 1};
        vt[4]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 0};
        vt[5]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, -1};
        vt[6]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        vt[7]  = '{5, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1};
        vt[8]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5};
        vt[9]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4};
        vt[10] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 3};
        vt[11] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 3};
        vt[12] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 3};
        vt[13] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 2};
        vt[14] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1};
        vt[15] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 0};
        vt[16] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1, -1};
        vt[17] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0};
        for (int i = 0; i < 18; i++) begin
            bus.m_ready = vt[i].rdy;
            for (int k = 0; k < vt[i].nload; k++) pend.push_back(vt[i].base + 8'(k));
            @(negedge clk);
            chk($sformatf("v%0d_ren", i),   bus.fifo_ren, vt[i].ren);
            chk($sformatf("v%0d_valid", i), bus.m_valid,  vt[i].vld);
            chk($sformatf("v%0d_busy", i),  bus.busy,     vt[i].busy);
            if (vt[i].vld) begin
                chk($sformatf("v%0d_data", i), bus.m_data, vt[i].data);
                chk($sformatf("v%0d_last", i), bus.m_last, vt[i].last);
            end
            if (vt[i].cnt >= 0) chk($sformatf("v%0d_count", i), bus.fifo_count, vt[i].cnt);
            @(posedge clk);
            #1;
        end

        // Reset while a read is in flight: that word must never appear.
        bus.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) pend.push_back(8'h50 + 8'(k));
        @(posedge clk);
        #1;
        chk("mid_ren_c0", bus.fifo_ren, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rd_log.delete();
        #1;
        chk("mid_rst_ren",   bus.fifo_ren, 1'b0);
        chk("mid_rst_valid", bus.m_valid,  1'b0);
        chk("mid_rst_data",  bus.m_data,   8'h00);
        chk("mid_rst_last",  bus.m_last,   1'b0);
        chk("mid_rst_busy",  bus.busy,     1'b0);
        @(negedge clk);
        chk("mid_rst_hold_ren", bus.fifo_ren, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                found = 1'b1;
                chk("post_mid_first_word", bus.m_data, 8'h51);
            end
        end
        chk("post_mid_word_seen", found, 1'b1);
        @(posedge clk);
        #1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_mid_idle", bus.busy, 1'b0);
`else
        // Full burst then timeout-flushed partial burst.
        bus.m_ready = 1'b1;
        seen_last.delete();
        for (int k = 0; k < 6; k++) pend.push_back(8'h60 + 8'(k));
        @(posedge clk);
        #1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            ren_tr[c] = bus.fifo_ren;
            if (c == 5) chk("burst_count_after", bus.fifo_count, 5'd2);
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 25; c++) begin
            chk($sformatf("burst_ren_c%0d", c), ren_tr[c],
                ((c >= 1 && c <= 4) || c == 21 || c == 22) ? 1'b1 : 1'b0);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("burst_beats", seen_last.size(), 6);
        if (seen_last.size() == 6) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("burst_last_%0d", k), seen_last[k], (k == 3 || k == 5) ? 1'b1 : 1'b0);
        end
`endif

        // Random writes and backpressure: no empty read, in-order delivery.
        for (int n = 0; n < 10000; n++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0 && (fq.size() + pend.size()) < DEPTH)
                pend.push_back(8'($urandom));
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            #1;
            done = (fq.size() == 0) && (pend.size() == 0) && (rd_log.size() == 0) && !bus.busy;
        end
        chk("rand_drained",    done,          1'b1);
        chk("rand_leftover",   rd_log.size(), 0);
        chk("empty_read_viol", n_viol,        0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side companion to the 16-entry overwrite-on-full FIFO. It owns the FIFO's read port (`ren`/`rdata`/`empty`/`count`) and delivers the words on a valid/ready stream through a 2-entry output buffer. It never reads while the FIFO is empty, so it never triggers the FIFO's read-while-empty write-pointer skip. Optionally it groups reads into bursts (see Configuration).

## Interface
Parameters:
- `DATA_W`, 8, word width; equals the FIFO data width.
- `CNT_W`, 5, width of the FIFO count.
- `BURST_LEN`, 4, words per burst in burst mode; 1..16.
- `TIMEOUT`, 15, cycles spent in WAIT before a partial burst is flushed; ≥1.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_count`  in  CNT_W  FIFO occupancy
- `fifo_rdata`  in  DATA_W  FIFO read data; valid the cycle after `fifo_ren`
- `fifo_ren`  out  1  FIFO read enable (combinational)
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  DATA_W  output word
- `m_last`  out  1  last word of a group
- `busy`  out  1  state ≠ IDLE, or the buffer is non-empty, or a read is in flight

## Operation
- **Output buffer:** 2 entries, in-order. Each entry holds {data, last}.
  - The head entry drives `m_data`/`m_last`.
  - `m_valid` = buffer non-empty.
  - A pop occurs when `m_valid && m_ready`.
- **In-flight tracking:** `ren_q` is a register holding last cycle's `fifo_ren`. `last_q` holds the last tag computed with that read.
  - When `ren_q`=1, `fifo_rdata` and `last_q` are pushed into the buffer at the clock edge.
- **Credit rule:** `fifo_ren` = `rst_n && allow && !fifo_empty && (occ + ren_q − pop < 2)`.
  - `occ` is the buffer occupancy (0..2).
  - The buffer therefore never overflows, and a push and a pop in the same cycle are both legal.
- **Streaming (no macro):**
  - `allow` = 1 at all times.
  - The last tag is `fifo_count == 1` at the time of the read.
- **Burst state machine (macro defined):**
  - IDLE:
    - `fifo_count` ≥ `BURST_LEN` → DRAIN, with `rem` = `BURST_LEN`.
    - `fifo_count` in 1..`BURST_LEN`−1 → WAIT, with `tmr` = 0.
  - WAIT:
    - `tmr` increments every cycle.
    - `fifo_count` ≥ `BURST_LEN` → DRAIN, with `rem` = `BURST_LEN`.
    - Otherwise, when `tmr` = `TIMEOUT`−1 → DRAIN, with `rem` = `fifo_count`.
  - DRAIN:
    - `allow` = 1 only in DRAIN.
    - Every `fifo_ren` decrements `rem`.
    - The last tag = (`rem` == 1).
    - The read that brings `rem` to 0 also moves the state to IDLE.
    - A new burst may begin on the following cycle, while the buffer still drains.
- **Widths:**
  - `rem` is 5 bits; it never underflows because reads occur only while `rem` > 0.
  - `tmr` is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
- **Reset (async, any time):**
  - Buffer, `ren_q`, `rem`, `tmr` cleared; state = IDLE.
  - An in-flight word is discarded.
  - Outputs during reset: `fifo_ren`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0.

## Timing
- **Latency:** `fifo_ren` high in cycle t → `fifo_rdata` captured at the end of t+1 → `m_valid` high in t+2.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, `fifo_ren` stays high every cycle and the stream carries 1 word/cycle.
- **Backpressure:** with `m_ready`=0, at most 2 reads are issued, then `fifo_ren` holds low.
  - `m_data`/`m_last` are stable while `m_valid && !m_ready`.
- **Last FIFO word:** a read at count = 1 updates count to 0 at the next edge. `fifo_empty` then blocks a further read in the same cycle, so the FIFO is never read while empty.
- **Burst mode start:** the first read occurs in the cycle after the IDLE/WAIT → DRAIN transition.
- **Burst mode timeout:** WAIT lasts exactly `TIMEOUT` cycles when no threshold is reached.

## Configuration
- Macro: `FIFO_DRAIN_BURST_EN`.
- Defined:
  - The IDLE/WAIT/DRAIN machine gates reads.
  - `m_last` marks the final word of each burst.
- Undefined:
  - No state machine; `rem` and `tmr` are not built.
  - Reads issue whenever credit is available and the FIFO is non-empty.
  - `m_last` marks the word read when `fifo_count` was 1.

## Test plan
- **Reset and streaming (no macro):** reset, then FIFO loaded with 3 words A,B,C and `m_ready`=1 → `fifo_ren` high for 3 consecutive cycles; A,B,C appear 2 cycles after their reads; `m_last`=1 only on C; `busy` falls 1 cycle after C is accepted.
- **Backpressure:** FIFO count = 5 and `m_ready`=0 → exactly 2 reads, then `fifo_ren`=0 and `fifo_count`=3. Releasing `m_ready` → words delivered in order, with no gap and no duplicate.
- **Full burst (macro, `BURST_LEN`=4):** count goes 0→6 → 4 reads; `m_last` on the 4th word; state back to IDLE with count = 2; then WAIT.
- **Timeout (macro, `TIMEOUT`=15):** count = 2 with no further writes → 15 cycles in WAIT, then 2 reads; `m_last` on the 2nd word.
- **Reset mid-burst:** `rst_n` pulled low 1 cycle after a read → all outputs 0 immediately; the in-flight word is never presented; `fifo_ren` stays 0 until `rst_n` is high.
- **Empty safety:** random writes with random `m_ready` over 10k cycles → `fifo_ren && fifo_empty` never occurs, and output order equals write order.
